// File: rtl/flit_activity_monitor_pkg.sv
// Shared types and default widths for the flit activity monitor.
// Holds the receive FSM encoding and the counter saturation ceiling.
package flit_act_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DEF_N        = 12;
    localparam int DEF_PAYLOAD  = 20;
    localparam int DEF_IDLE_GAP = 4;
    localparam int DEF_CW       = 16;

    localparam logic [DEF_CW-1:0] CW_MAX = '1;

endpackage

// File: rtl/flit_activity_monitor_if.sv
// Flit input stream and per-packet report channel of the activity monitor.
// Optional rpt_max_tog field is present only when FLIT_ACT_MAX_EN is defined.
interface flit_activity_monitor_if
    import flit_act_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int CW = DEF_CW
);
`ifdef FLIT_ACT_MAX_EN
    localparam int PW = $clog2(N + 1);
    logic [PW-1:0] rpt_max_tog;
`endif
    logic          in_valid;
    logic [N-1:0]  in_data;
    logic          rpt_valid;
    logic          rpt_ready;
    logic [CW-1:0] rpt_flits;
    logic [CW-1:0] rpt_toggles;
    logic          rpt_len_err;
    logic          rpt_overrun;

    modport master (
`ifdef FLIT_ACT_MAX_EN
        input  rpt_max_tog,
`endif
        output in_valid, in_data, rpt_ready,
        input  rpt_valid, rpt_flits, rpt_toggles, rpt_len_err, rpt_overrun
    );

    modport slave (
`ifdef FLIT_ACT_MAX_EN
        output rpt_max_tog,
`endif
        input  in_valid, in_data, rpt_ready,
        output rpt_valid, rpt_flits, rpt_toggles, rpt_len_err, rpt_overrun
    );

endinterface

// File: rtl/flit_activity_monitor_popcount.sv
// Combinational population count of an N-bit word.
// Zero latency; no flow control.
module flit_popcount #(
    parameter int N  = 12,
    parameter int PW = $clog2(N + 1)
) (
    input  logic [N-1:0]  din,
    output logic [PW-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + PW'(din[i]);
        end
    end

endmodule

// File: rtl/flit_activity_monitor.sv
// Purpose: delimits flit packets by idle gaps, counts flits and bit toggles per packet.
// Latency: report registered on the edge ending the IDLE_GAP-th idle cycle after the last flit.
// Backpressure: none on input; a report closing while one is pending and unaccepted is dropped (sticky rpt_overrun). FLIT_ACT_MAX_EN adds rpt_max_tog.
module flit_activity_monitor
    import flit_act_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int PAYLOAD  = DEF_PAYLOAD,
    parameter int IDLE_GAP = DEF_IDLE_GAP,
    parameter int CW       = DEF_CW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    flit_activity_monitor_if.slave bus,
    output logic [CW-1:0]          pkt_count,
    output logic                   busy
);

    localparam int PW = $clog2(N + 1);
    localparam logic [CW-1:0] SAT_MAX = '1;

    state_t        state, state_nxt;
    logic [N-1:0]  prev_data;
    logic [CW-1:0] flit_cnt, tog_acc;
    logic [7:0]    idle_cnt, idle_nxt;
    logic [PW-1:0] tog;
    logic          acc_first, acc_more, close;
    logic          rpt_valid, rpt_len_err, rpt_overrun;
    logic [CW-1:0] rpt_flits, rpt_toggles;

    flit_popcount #(.N(N)) u_pop (
        .din (bus.in_data ^ prev_data),
        .cnt (tog)
    );

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CW] ? SAT_MAX : s[CW-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_nxt;
        end
    end

    // idle_cnt holds idle cycles already seen, so the current one is idle_cnt+1
    always_comb begin
        state_nxt = state;
        idle_nxt  = idle_cnt;
        acc_first = 1'b0;
        acc_more  = 1'b0;
        close     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    acc_first = 1'b1;
                    state_nxt = RECV;
                end
            end
            RECV: begin
                if (bus.in_valid) begin
                    acc_more = 1'b1;
                end else if (IDLE_GAP == 1) begin
                    close     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = GAP;
                    idle_nxt  = 8'd1;
                end
            end
            GAP: begin
                if (bus.in_valid) begin
                    acc_more  = 1'b1;
                    state_nxt = RECV;
                end else if (idle_cnt + 8'd1 == 8'(IDLE_GAP)) begin
                    close     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    idle_nxt = idle_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // prev_data survives packet close: toggles are counted across packet boundaries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_data <= '0;
            flit_cnt  <= '0;
            tog_acc   <= '0;
        end else if (acc_first) begin
            prev_data <= bus.in_data;
            flit_cnt  <= CW'(1);
            tog_acc   <= CW'(tog);
        end else if (acc_more) begin
            prev_data <= bus.in_data;
            flit_cnt  <= sat_add(flit_cnt, CW'(1));
            tog_acc   <= sat_add(tog_acc, CW'(tog));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_valid   <= 1'b0;
            rpt_flits   <= '0;
            rpt_toggles <= '0;
            rpt_len_err <= 1'b0;
            rpt_overrun <= 1'b0;
            pkt_count   <= '0;
        end else if (close) begin
            pkt_count <= pkt_count + CW'(1);
            if (!rpt_valid || bus.rpt_ready) begin
                rpt_valid   <= 1'b1;
                rpt_flits   <= flit_cnt;
                rpt_toggles <= tog_acc;
                rpt_len_err <= (flit_cnt != CW'(PAYLOAD));
            end else begin
                rpt_overrun <= 1'b1;
            end
        end else if (rpt_valid && bus.rpt_ready) begin
            rpt_valid <= 1'b0;
        end
    end

`ifdef FLIT_ACT_MAX_EN
    logic [PW-1:0] max_acc, rpt_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_acc <= '0;
            rpt_max <= '0;
        end else begin
            if (acc_first) begin
                max_acc <= tog;
            end else if (acc_more && (tog > max_acc)) begin
                max_acc <= tog;
            end
            if (close && (!rpt_valid || bus.rpt_ready)) begin
                rpt_max <= max_acc;
            end
        end
    end

    assign bus.rpt_max_tog = rpt_max;
`endif

    assign bus.rpt_valid   = rpt_valid;
    assign bus.rpt_flits   = rpt_flits;
    assign bus.rpt_toggles = rpt_toggles;
    assign bus.rpt_len_err = rpt_len_err;
    assign bus.rpt_overrun = rpt_overrun;
    assign busy            = (state != IDLE);

endmodule

// File: tb/tb_flit_activity_monitor.sv
// Directed bench for flit_activity_monitor; FLIT_ACT_MAX_EN enables the max-toggle case.
module tb_flit_activity_monitor;

    localparam int N  = 12;
    localparam int CW = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] pkt_count;
    logic          busy;

    always #5 clk = ~clk;

    flit_activity_monitor_if #(.N(N), .CW(CW)) bus ();

    flit_activity_monitor #(
        .N        (N),
        .PAYLOAD  (20),
        .IDLE_GAP (4),
        .CW       (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .pkt_count (pkt_count),
        .busy      (busy)
    );

    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            rises = 0;
    int            vld_cyc = 0;
    int            rise_cyc = 0;
    int            last_flit_cyc = 0;
    logic          last_vld = 1'b0;
    logic [CW-1:0] cap_flits = '0;
    logic [CW-1:0] cap_tog = '0;
    logic          cap_len = 1'b0;
`ifdef FLIT_ACT_MAX_EN
    logic [3:0]    cap_max = '0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample outputs 1ns after the edge; snapshot each new report.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.rpt_valid) begin
            vld_cyc++;
            if (!last_vld) begin
                rises++;
                rise_cyc  = cyc;
                cap_flits = bus.rpt_flits;
                cap_tog   = bus.rpt_toggles;
                cap_len   = bus.rpt_len_err;
`ifdef FLIT_ACT_MAX_EN
                cap_max   = bus.rpt_max_tog;
`endif
            end
        end
        last_vld = bus.rpt_valid;
    endtask

    task automatic flit(input logic [N-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        last_flit_cyc = cyc;
        bus.in_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic clr();
        rises   = 0;
        vld_cyc = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.rpt_ready = 1'b0;
        repeat (2) step();
        chk("rst_rpt_valid", 32'(bus.rpt_valid), 0);
        chk("rst_rpt_flits", 32'(bus.rpt_flits), 0);
        chk("rst_rpt_toggles", 32'(bus.rpt_toggles), 0);
        chk("rst_len_err", 32'(bus.rpt_len_err), 0);
        chk("rst_overrun", 32'(bus.rpt_overrun), 0);
        chk("rst_pkt_count", 32'(pkt_count), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        step();

        // Alternating full-swing packet: 20 flits x 12 toggles
        clr();
        for (int i = 0; i < 20; i++) flit((i % 2 == 0) ? 12'hFFF : 12'h000);
        chk("t1_busy_mid", 32'(busy), 1);
        idle(7);
        chk("t1_rises", 32'(rises), 1);
        chk("t1_close_latency", 32'(rise_cyc - last_flit_cyc), 4);
        chk("t1_flits", 32'(cap_flits), 20);
        chk("t1_toggles", 32'(cap_tog), 240);
        chk("t1_len_err", 32'(cap_len), 0);
        chk("t1_pkt_count", 32'(pkt_count), 1);
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_valid_held", 32'(bus.rpt_valid), 1);
        bus.rpt_ready = 1'b1;
        step();
        chk("t1_valid_drop", 32'(bus.rpt_valid), 0);

        // Short packet, first flit compared with last flit (0x000) of previous packet
        clr();
        flit(12'h800);
        flit(12'h000);
        flit(12'h001);
        idle(7);
        chk("t2_rises", 32'(rises), 1);
        chk("t2_valid_cycles", 32'(vld_cyc), 1);
        chk("t2_toggles", 32'(cap_tog), 3);
        chk("t2_flits", 32'(cap_flits), 3);
        chk("t2_len_err", 32'(cap_len), 1);

        // 3-cycle gap stays inside the packet
        clr();
        for (int i = 0; i < 5; i++) flit(12'h001);
        idle(3);
        for (int i = 0; i < 5; i++) flit(12'h001);
        idle(7);
        chk("t3_rises", 32'(rises), 1);
        chk("t3_flits", 32'(cap_flits), 10);
        chk("t3_toggles", 32'(cap_tog), 0);
        chk("t3_pkt_count", 32'(pkt_count), 3);

        // Overrun: two closes with rpt_ready low
        bus.rpt_ready = 1'b0;
        do_reset();
        chk("t4_pkt_count_rst", 32'(pkt_count), 0);
        clr();
        for (int i = 0; i < 20; i++) flit((i % 2 == 0) ? 12'h00F : 12'h000);
        idle(7);
        chk("t4_first_valid", 32'(bus.rpt_valid), 1);
        chk("t4_first_toggles", 32'(bus.rpt_toggles), 80);
        chk("t4_first_overrun", 32'(bus.rpt_overrun), 0);
        for (int i = 0; i < 20; i++) flit(12'hAAA);
        idle(7);
        chk("t4_rises", 32'(rises), 1);
        chk("t4_held_flits", 32'(bus.rpt_flits), 20);
        chk("t4_held_toggles", 32'(bus.rpt_toggles), 80);
        chk("t4_overrun", 32'(bus.rpt_overrun), 1);
        chk("t4_pkt_count", 32'(pkt_count), 2);
        bus.rpt_ready = 1'b1;
        step();
        chk("t4_valid_drop", 32'(bus.rpt_valid), 0);
        chk("t4_overrun_sticky", 32'(bus.rpt_overrun), 1);

        // Asynchronous reset mid-packet
        clr();
        for (int i = 0; i < 10; i++) flit(12'h555);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(bus.rpt_valid), 0);
        chk("t5_async_busy", 32'(busy), 0);
        chk("t5_async_pkt_count", 32'(pkt_count), 0);
        chk("t5_async_overrun", 32'(bus.rpt_overrun), 0);
        chk("t5_async_toggles", 32'(bus.rpt_toggles), 0);
        chk("t5_async_flits", 32'(bus.rpt_flits), 0);
        repeat (2) step();
        rst_n = 1'b1;
        idle(7);
        chk("t5_no_report", 32'(rises), 0);
        for (int i = 0; i < 20; i++) flit(12'hFFF);
        idle(7);
        chk("t5_rises", 32'(rises), 1);
        chk("t5_toggles", 32'(cap_tog), 12);
        chk("t5_flits", 32'(cap_flits), 20);
        chk("t5_len_err", 32'(cap_len), 0);
        chk("t5_pkt_count", 32'(pkt_count), 1);

`ifdef FLIT_ACT_MAX_EN
        do_reset();
        clr();
        flit(12'h000);
        flit(12'h00F);
        flit(12'hFFF);
        idle(7);
        chk("t6_rises", 32'(rises), 1);
        chk("t6_max_tog", 32'(cap_max), 8);
        chk("t6_toggles", 32'(cap_tog), 12);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/flit_activity_monitor.md
Name: flit_activity_monitor

Overview:
- Receive end of the flit-injection path used for adder characterization.
- Consumes the flit stream at the datapath output, one flit per cycle when valid.
- Delimits packets by idle gaps, counts flits per packet, and accumulates bit-toggle activity (Hamming distance between consecutive flits) as the switching-energy proxy.
- Emits one per-packet report over a valid/ready handshake.

Parameters:
- N, 12, flit data width in bits.
- PAYLOAD, 20, expected flits per packet; used for the length check.
- IDLE_GAP, 4, consecutive idle cycles that close a packet (1..255).
- CW, 16, width of the flit and toggle counters (saturating).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  flit present this cycle.
- in_data  in  N  flit payload.
- rpt_valid  out  1  report available.
- rpt_ready  in  1  report consumer accepts.
- rpt_flits  out  CW  flits in the reported packet.
- rpt_toggles  out  CW  summed toggles in the reported packet.
- rpt_len_err  out  1  rpt_flits != PAYLOAD.
- rpt_overrun  out  1  sticky: a report was dropped.
- pkt_count  out  CW  packets closed since reset (wraps).
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync deassert by design): FSM=IDLE; prev_data=0; all counters=0; rpt_*=0; pkt_count=0; busy=0.
- FSM IDLE:
  - in_valid=1 -> RECV.
  - flit_cnt=1; tog_acc=popcount(in_data^prev_data); prev_data=in_data.
- FSM RECV:
  - Each in_valid=1: flit_cnt+=1 and tog_acc+=popcount(in_data^prev_data), both saturating at 2^CW-1; prev_data updated.
  - in_valid=0 -> GAP with idle_cnt=1.
- FSM GAP:
  - in_valid=1 before idle_cnt reaches IDLE_GAP: the gap is intra-packet; accumulate the flit, go back to RECV.
  - in_valid=0 with idle_cnt==IDLE_GAP: close the packet and go to IDLE.
  - Otherwise idle_cnt+=1.
- prev_data is never cleared at packet close. Activity is measured bus-continuously; the first flit of a packet is compared against the last flit of the previous packet.
- Close timing: with the last flit at cycle t, rpt_valid rises at the edge ending cycle t+IDLE_GAP. rpt_* are registered; pkt_count increments on the same edge.
- Report handshake:
  - rpt_valid and rpt_* hold until rpt_valid&&rpt_ready; rpt_valid drops on the next edge.
  - A close in the same cycle as acceptance loads the new report and keeps rpt_valid=1.
- Overrun: a close while a report is pending and not being accepted discards the new report (the old report is kept) and sets rpt_overrun=1 until reset.
- Reception never stalls; there is no backpressure on in_*.
- in_data is ignored when in_valid=0.
- Reset mid-packet: partial counts are discarded and no report is produced.

Optional Feature:
- Macro: FLIT_ACT_MAX_EN.
- Defined:
  - Adds output rpt_max_tog [$clog2(N+1)-1:0], the maximum single-flit toggle count in the packet.
  - Reset 0; registered with the other rpt_* fields and follows the same hold/overrun rules.
- Undefined: the port and its tracking logic are absent.

Decomposition:
- Package flit_act_pkg:
  - FSM state enum (IDLE, RECV, GAP).
  - Default widths and a CW saturation-max constant.
- Sub-module flit_popcount: combinational, N-bit in, $clog2(N+1)-bit count out.
  - Used for in_data^prev_data.

Test Plan:
- Reset, then 20 flits 0x000/0xFFF alternating starting with 0xFFF, then 7 idle cycles: rpt_flits=20, rpt_toggles=240, rpt_len_err=0, rpt_valid rises 4 cycles after the last flit, pkt_count=1.
- Packet of flits 0x800,0x000,0x001 with rpt_ready=1 held: rpt_toggles=1+1+1=3, rpt_flits=3, rpt_len_err=1; rpt_valid high exactly one cycle.
- 5 flits, 3 idle cycles, 5 flits, then 4 idle cycles: exactly one report with rpt_flits=10 (the 3-cycle gap is intra-packet).
- rpt_ready=0, send two 20-flit packets: the first report is held unchanged, rpt_overrun=1 after the second close, pkt_count=2; raising rpt_ready clears rpt_valid.
- Drop rst_n asynchronously after 10 flits, then release: all outputs 0 immediately, no report; a following 20-flit 0xFFF-constant packet gives rpt_toggles=12.
- With FLIT_ACT_MAX_EN, flits 0x000,0x00F,0xFFF: rpt_max_tog=8, rpt_toggles=12.
